// File: rtl/sram_seq_macro.sv
// Behavioural column-muxed SRAM macro with a precharge / wordline / sense sequencer.
// Requests use a req/ready handshake; writes are bit-masked and reads are held in rdata.
module sram_seq_macro #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned COL_BITS   = 2,
  parameter int unsigned PCH_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         req,
  output logic                         ready,
  input  logic                         we,
  input  logic [ROW_BITS+COL_BITS-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W-1:0]            wmask,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rvalid,
  output logic                         ack,
  output logic                         n_pch,
  output logic [(2**ROW_BITS)-1:0]     wl,
  output logic [(2**COL_BITS)-1:0]     col
);

  localparam int unsigned AddrW = ROW_BITS + COL_BITS;
  localparam int unsigned Depth = 2**AddrW;

  typedef enum logic [1:0] {StIdle, StPch, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [AddrW-1:0]    addr_q;
  logic [DATA_W-1:0]   wdata_q, wmask_q, rdata_q;
  logic [ROW_BITS-1:0] row_idx;
  logic [COL_BITS-1:0] col_idx;
  logic                accept;

  // Storage is deliberately outside the reset domain: reset never clears it.
  logic [DATA_W-1:0] mem [Depth];

  assign accept  = (state_q == StIdle) && req;
  assign row_idx = addr_q[AddrW-1:COL_BITS];
  assign col_idx = addr_q[COL_BITS-1:0];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        wmask_q <= wmask;
      end
      if (state_q == StAccess && !we_q) begin
        rdata_q <= mem[addr_q];
      end
    end
  end

  // A reset before the ACCESS-ending edge forces StIdle asynchronously, so no commit occurs.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && we_q) begin
      mem[addr_q] <= (mem[addr_q] & ~wmask_q) | (wdata_q & wmask_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StPch;
          cnt_d   = 4'(PCH_CYCLES - 1);
        end
      end
      StPch: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready  = (state_q == StIdle);
    n_pch  = (state_q != StPch);
    ack    = (state_q == StDone);
    rvalid = (state_q == StDone) && !we_q;
    rdata  = rdata_q;
    wl     = '0;
    col    = '0;
    if (state_q == StAccess) begin
      wl[row_idx]  = 1'b1;
      col[col_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_seq_macro.sv
// Randomised self-checking bench for sram_seq_macro: a small 8-bit / PCH=1 instance and a
// 16-bit / 1024-word / PCH=4 instance, both checked cycle by cycle against a reference model.
module tb_sram_seq_macro;

  localparam int unsigned PA = 1;
  localparam int unsigned PB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_reset;

  logic        req_a, we_a, ready_a, rvalid_a, ack_a, n_pch_a;
  logic [6:0]  addr_a;
  logic [7:0]  wdata_a, wmask_a, rdata_a;
  logic [31:0] wl_a;
  logic [3:0]  col_a;

  logic         req_b, we_b, ready_b, rvalid_b, ack_b, n_pch_b;
  logic [9:0]   addr_b;
  logic [15:0]  wdata_b, wmask_b, rdata_b;
  logic [127:0] wl_b;
  logic [7:0]   col_b;

  sram_seq_macro #(.DATA_W(8), .ROW_BITS(5), .COL_BITS(2), .PCH_CYCLES(PA)) u_dut_a (
    .clk(clk), .n_reset(n_reset), .req(req_a), .ready(ready_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .wmask(wmask_a), .rdata(rdata_a), .rvalid(rvalid_a), .ack(ack_a),
    .n_pch(n_pch_a), .wl(wl_a), .col(col_a)
  );

  sram_seq_macro #(.DATA_W(16), .ROW_BITS(7), .COL_BITS(3), .PCH_CYCLES(PB)) u_dut_b (
    .clk(clk), .n_reset(n_reset), .req(req_b), .ready(ready_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .wmask(wmask_b), .rdata(rdata_b), .rvalid(rvalid_b), .ack(ack_b),
    .n_pch(n_pch_b), .wl(wl_b), .col(col_b)
  );

  int           sel;
  logic         obs_ready, obs_rvalid, obs_ack, obs_n_pch;
  logic [15:0]  obs_rdata;
  logic [127:0] obs_wl;
  logic [7:0]   obs_col;

  always_comb begin
    if (sel == 0) begin
      obs_ready  = ready_a;
      obs_rvalid = rvalid_a;
      obs_ack    = ack_a;
      obs_n_pch  = n_pch_a;
      obs_rdata  = 16'(rdata_a);
      obs_wl     = 128'(wl_a);
      obs_col    = 8'(col_a);
    end else begin
      obs_ready  = ready_b;
      obs_rvalid = rvalid_b;
      obs_ack    = ack_b;
      obs_n_pch  = n_pch_b;
      obs_rdata  = rdata_b;
      obs_wl     = wl_b;
      obs_col    = col_b;
    end
  end

  // Reference storage: one word per address, updated only when an access completes.
  logic [15:0] mem_a [128];
  logic [15:0] mem_b [1024];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (sel %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [9:0] a,
                       input logic [15:0] d, input logic [15:0] m);
    if (s == 0) begin
      req_a = r; we_a = w; addr_a = a[6:0]; wdata_a = d[7:0]; wmask_a = m[7:0];
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d; wmask_b = m;
    end
  endtask

  task automatic check_reset_vals(input int s);
    sel = s;
    #1;
    check("rst_ready", 128'(obs_ready), 128'(1));
    check("rst_n_pch", 128'(obs_n_pch), 128'(1));
    check("rst_ack", 128'(obs_ack), 128'(0));
    check("rst_rvalid", 128'(obs_rvalid), 128'(0));
    check("rst_wl", obs_wl, 128'(0));
    check("rst_col", 128'(obs_col), 128'(0));
    check("rst_rdata", 128'(obs_rdata), 128'(0));
  endtask

  // Call at a negedge with the target instance idle; returns at the negedge of cycle P+3.
  // With hold set, req stays high and the other inputs are scrambled while busy.
  task automatic access(input int s, input logic w, input int a, input logic [15:0] d,
                        input logic [15:0] m, input bit hold);
    int          p;
    int          cb;
    logic [15:0] dm;
    logic [15:0] exp_rd;
    logic [127:0] exp_wl;
    logic [7:0]  exp_col;
    p  = (s == 0) ? PA : PB;
    cb = (s == 0) ? 2 : 3;
    dm = (s == 0) ? 16'h00ff : 16'hffff;
    sel = s;
    #1;
    check("ready_idle", 128'(obs_ready), 128'(1));
    drive(s, 1'b1, w, 10'(a), d, m);
    exp_wl  = 128'(1) << (a >> cb);
    exp_col = 8'(1) << (a & ((1 << cb) - 1));
    exp_rd  = 16'hxxxx;
    if (s == 0) begin
      if (w) mem_a[a] = ((mem_a[a] & ~m) | (d & m)) & dm;
      exp_rd = mem_a[a];
    end else begin
      if (w) mem_b[a] = ((mem_b[a] & ~m) | (d & m)) & dm;
      exp_rd = mem_b[a];
    end
    @(posedge clk);
    for (int k = 1; k <= p + 2; k++) begin
      @(negedge clk);
      #1;
      check("ready_busy", 128'(obs_ready), 128'(0));
      check("n_pch", 128'(obs_n_pch), 128'(k > p));
      check("wl", obs_wl, (k == p + 1) ? exp_wl : 128'(0));
      check("col", 128'(obs_col), (k == p + 1) ? 128'(exp_col) : 128'(0));
      check("ack", 128'(obs_ack), 128'(k == p + 2));
      check("rvalid", 128'(obs_rvalid), 128'((k == p + 2) && !w));
      check("pch_wl_excl", 128'(!obs_n_pch && (|obs_wl)), 128'(0));
      if (k == p + 2 && !w) check("rdata", 128'(obs_rdata), 128'(exp_rd));
      if (hold) begin
        drive(s, 1'b1, 1'($urandom), 10'($urandom), 16'($urandom), 16'($urandom));
      end else begin
        drive(s, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);
      end
    end
    @(negedge clk);
    #1;
    check("ready_again", 128'(obs_ready), 128'(1));
    if (!w) check("rdata_held", 128'(obs_rdata), 128'(exp_rd));
  endtask

  initial begin
    sel = 0;
    n_reset = 1'b0;
    drive(0, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    n_reset = 1'b1;
    @(negedge clk);

    // Instance A: basic write/read at row 31 col 3, then masked writes.
    access(0, 1'b1, 'h7f, 16'h3c, 16'hff, 1'b0);
    access(0, 1'b0, 'h7f, 16'h00, 16'h00, 1'b0);
    access(0, 1'b1, 'h10, 16'hff, 16'hff, 1'b0);
    access(0, 1'b1, 'h10, 16'h00, 16'h0f, 1'b0);
    access(0, 1'b0, 'h10, 16'h00, 16'h00, 1'b0);
    access(0, 1'b1, 'h10, 16'h55, 16'h00, 1'b0);
    access(0, 1'b0, 'h10, 16'h00, 16'h00, 1'b0);

    // Fill every word of A so random reads are defined, then randomised traffic.
    for (int i = 0; i < 128; i++) access(0, 1'b1, i, 16'($urandom), 16'hffff, 1'b1);
    for (int i = 0; i < 200; i++) begin
      access(0, 1'($urandom), int'($urandom_range(0, 127)), 16'($urandom), 16'($urandom),
             1'($urandom));
    end
    drive(0, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);

    // Instance B: whole-array pattern, then back-to-back readback with req held high.
    for (int i = 0; i < 1024; i++) access(1, 1'b1, i, 16'(i) ^ 16'ha5a5, 16'hffff, 1'b0);
    for (int i = 0; i < 1024; i++) access(1, 1'b0, i, 16'h0000, 16'h0000, 1'b1);
    drive(1, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);
    for (int i = 0; i < 60; i++) begin
      access(1, 1'($urandom), int'($urandom_range(0, 1023)), 16'($urandom), 16'($urandom),
             1'($urandom));
    end
    drive(1, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);
    @(negedge clk);

    // Reset mid-PCH of a write to 0x05 on B: outputs clear at once, the word is untouched.
    sel = 1;
    drive(1, 1'b1, 1'b1, 10'h005, 16'h00a5, 16'hffff);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 10'd0, 16'd0, 16'd0);
    @(negedge clk);
    n_reset = 1'b0;
    check_reset_vals(1);
    check_reset_vals(0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    access(1, 1'b0, 'h005, 16'h0000, 16'h0000, 1'b0);
    access(0, 1'b0, 'h7f, 16'h0000, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
